// File: rtl/vector_alu_wb_ctrl.sv
// Issue/writeback controller for vector_alu: tracks in-flight destinations through a
// latency-matched tag pipeline, steers results to the register files, flags RAW/WAW hazards.
module vector_alu_wb_ctrl #(
  parameter int unsigned LAT  = 8,
  parameter int unsigned NREG = 32,
  localparam int unsigned RW  = $clog2(NREG),
  localparam int unsigned IW  = $clog2(LAT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           issue_valid,
  input  logic [4:0]     issue_op,
  input  logic [RW-1:0]  issue_dst,
  input  logic [RW-1:0]  q_vsrc1,
  input  logic [RW-1:0]  q_vsrc2,
  input  logic [RW-1:0]  q_ssrc,
  output logic           issue_ready,
  input  logic [127:0]   vout,
  input  logic [31:0]    rout,
  output logic           wb_vvalid,
  output logic [RW-1:0]  wb_vdst,
  output logic [127:0]   wb_vdata,
  output logic           wb_svalid,
  output logic [RW-1:0]  wb_sdst,
  output logic [31:0]    wb_sdata,
  output logic           illegal_op,
  output logic [IW-1:0]  inflight
);

  typedef enum logic [1:0] {ClsNone, ClsScalar, ClsVector, ClsIllegal} cls_e;

  logic              stg_valid_q [LAT];
  cls_e              stg_cls_q   [LAT];
  logic [RW-1:0]     stg_dst_q   [LAT];

  logic [NREG-1:0]   vbusy_q, vbusy_d;
  logic [NREG-1:0]   sbusy_q, sbusy_d;
  logic [IW-1:0]     inflight_q, inflight_d;
  logic              illegal_q;

  cls_e              issue_cls;
  logic              hazard;
  logic              accept;
  logic              retire;

  always_comb begin
    unique case (issue_op) inside
      5'd0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd8, 5'd9:   issue_cls = ClsScalar;
      [5'd3:5'd5], [5'd10:5'd14], [5'd16:5'd18]: issue_cls = ClsVector;
      5'd15:                                      issue_cls = ClsNone;
      default:                                    issue_cls = ClsIllegal;
    endcase
  end

  // Destination is only checked against the file the op will actually write.
  always_comb begin
    hazard = vbusy_q[q_vsrc1] | vbusy_q[q_vsrc2] | sbusy_q[q_ssrc];
    if (issue_cls == ClsVector) hazard = hazard | vbusy_q[issue_dst];
    if (issue_cls == ClsScalar) hazard = hazard | sbusy_q[issue_dst];
  end

  assign issue_ready = en & ~hazard;
  assign accept      = issue_valid & issue_ready & (issue_cls != ClsIllegal);
  assign retire      = en & stg_valid_q[LAT-1];

  assign wb_vvalid = retire & (stg_cls_q[LAT-1] == ClsVector);
  assign wb_svalid = retire & (stg_cls_q[LAT-1] == ClsScalar);
  assign wb_vdst   = wb_vvalid ? stg_dst_q[LAT-1] : '0;
  assign wb_sdst   = wb_svalid ? stg_dst_q[LAT-1] : '0;
  assign wb_vdata  = vout;
  assign wb_sdata  = rout;

  assign illegal_op = illegal_q;
  assign inflight   = inflight_q;

  // Clear first, then set, so a same-edge set wins.
  always_comb begin
    vbusy_d = vbusy_q;
    sbusy_d = sbusy_q;
    if (wb_vvalid) vbusy_d[stg_dst_q[LAT-1]] = 1'b0;
    if (wb_svalid) sbusy_d[stg_dst_q[LAT-1]] = 1'b0;
    if (accept && issue_cls == ClsVector) vbusy_d[issue_dst] = 1'b1;
    if (accept && issue_cls == ClsScalar) sbusy_d[issue_dst] = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q + IW'(accept) - IW'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LAT); i++) begin
        stg_valid_q[i] <= 1'b0;
        stg_cls_q[i]   <= ClsNone;
        stg_dst_q[i]   <= '0;
      end
    end else if (en) begin
      stg_valid_q[0] <= accept;
      stg_cls_q[0]   <= issue_cls;
      stg_dst_q[0]   <= issue_dst;
      for (int i = 1; i < int'(LAT); i++) begin
        stg_valid_q[i] <= stg_valid_q[i-1];
        stg_cls_q[i]   <= stg_cls_q[i-1];
        stg_dst_q[i]   <= stg_dst_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vbusy_q    <= '0;
      sbusy_q    <= '0;
      inflight_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      vbusy_q    <= vbusy_d;
      sbusy_q    <= sbusy_d;
      inflight_q <= inflight_d;
      illegal_q  <= issue_valid & issue_ready & (issue_cls == ClsIllegal);
    end
  end

endmodule
